// File: rtl/gshare_pkg.sv
// Shared encodings and default widths for the gshare pattern history table.
package gshare_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int HIST_W_DEF = 14;
  localparam int IDX_W_DEF  = 14;

  localparam logic [1:0] SNT      = 2'b00;
  localparam logic [1:0] WNT      = 2'b01;
  localparam logic [1:0] WT       = 2'b10;
  localparam logic [1:0] ST       = 2'b11;
  localparam logic [1:0] INIT_CTR = WNT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gshare_pht_sat_ctr2.sv
// Combinational 2-bit saturating counter step: moves toward ST when taken,
// toward SNT otherwise, holding at either end.
module sat_ctr2
  import gshare_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next_ctr
);

  always_comb begin
    next_ctr = cur;
    if (taken) begin
      if (cur != ST) next_ctr = cur + 2'd1;
    end else begin
      if (cur != SNT) next_ctr = cur - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// gshare PHT: index = PC ^ history, registered 1-cycle prediction, 2-stage
// counter training; a post-reset sweep initialises every counter to weak-NT.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int HIST_W = HIST_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_req,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic [HIST_W-1:0] ghr,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic              ready
);

  localparam int              ENTRIES = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST   = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep;
  logic [1:0]       pht [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic             run;

  logic             upd_vld_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;
  logic [1:0]       upd_cur, upd_nxt;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_dat;

  // PC bits below the instruction alignment and history bits above the index
  // width do not contribute to the index.
  logic unused_bits;
  assign unused_bits = ^{pred_pc, ghr};

  assign idx   = pred_pc[IDX_W+1:2] ^ ghr[IDX_W-1:0];
  assign run   = (state == RUN);
  assign ready = run;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep <= sweep + 1'b1;
    end
  end

  assign upd_cur = pht[upd_idx_q];

  sat_ctr2 u_sat_ctr2 (
    .cur      (upd_cur),
    .taken    (upd_taken_q),
    .next_ctr (upd_nxt)
  );

  // Single write port: the sweep owns it during INIT, the update stage in RUN.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sweep;
    wr_dat = INIT_CTR;
    if (!run) begin
      wr_en = 1'b1;
    end else if (upd_vld_q) begin
      wr_en  = 1'b1;
      wr_idx = upd_idx_q;
      wr_dat = upd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= pred_req && run;
      if (pred_req && run) begin
        pred_idx   <= idx;
        pred_taken <= pht[idx][1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_vld_q   <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_vld_q <= upd_en && run;
      if (upd_en && run) begin
        upd_idx_q   <= upd_idx;
        upd_taken_q <= upd_taken;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboarded random + directed bench for gshare_pht against an array-of-counters model.
module tb_gshare_pht;

  localparam int IDX_W = 14;
  localparam int N     = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic [13:0] ghr = '0;
  logic        upd_en = 1'b0;
  logic [13:0] upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        pred_valid, pred_taken, ready;
  logic [13:0] pred_idx;

  always #5 clk = ~clk;

  gshare_pht #(.PC_W(32), .HIST_W(14), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .ghr        (ghr),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_en     (upd_en),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .ready      (ready)
  );

  typedef struct {
    int idx;
    bit taken;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mdl[N];
  bit   pend_v = 1'b0;
  int   pend_i = 0;
  bit   pend_t = 1'b0;
  int   edge_cnt = 0;
  int   rise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_valid", pred_valid, 1);
        if (pred_valid) begin
          chk("pred_idx", pred_idx, e.idx);
          chk("pred_taken", pred_taken, e.taken);
        end
      end else if (pred_valid) begin
        chk("pred_valid_unexpected", pred_valid, 0);
      end
    end
  end

  // Model: a request sees counters as they stand before this edge; an update
  // accepted at one edge changes its counter at the following edge.
  task automatic step(input bit preq, input logic [31:0] pc, input logic [13:0] g,
                      input bit uen, input logic [13:0] ui, input bit ut);
    bit   acc;
    int   ix;
    exp_t e;
    @(negedge clk);
    #1;
    pred_req = preq; pred_pc = pc; ghr = g;
    upd_en = uen; upd_idx = ui; upd_taken = ut;
    acc = (edge_cnt >= N);
    if (acc && preq) begin
      ix = int'((pc >> 2) & 32'h3fff) ^ int'(g);
      e.idx = ix;
      e.taken = (mdl[ix] >= 2);
      exp_q.push_back(e);
    end
    if (pend_v) mdl[pend_i] = sat(mdl[pend_i], pend_t);
    pend_v = acc && uen;
    pend_i = int'(ui);
    pend_t = ut;
    @(posedge clk);
    edge_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pred(input logic [31:0] pc, input logic [13:0] g);
    step(1, pc, g, 0, 0, 0);
  endtask

  task automatic upd(input logic [13:0] ui, input bit ut);
    step(0, 0, 0, 1, ui, ut);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #1;
    reset = 1'b0; pred_req = 1'b0; upd_en = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_idx", pred_idx, 0);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    pend_v = 1'b0;
    edge_cnt = 0;
    foreach (mdl[i]) mdl[i] = 1;
    @(posedge clk);
    edge_cnt++;
  endtask

  // Random traffic while initialising; must be ignored until ready rises.
  task automatic run_init(output int r);
    r = -1;
    for (int k = 0; k < N + 200 && r < 0; k++) begin
      step(1'($urandom), $urandom, 14'($urandom), 1'($urandom), 14'($urandom), 1'($urandom));
      #1;
      if (ready) r = edge_cnt;
    end
  endtask

  initial begin
    logic [31:0] pc;
    do_reset(3);
    run_init(rise);
    chk("init_cycles", rise, N);

    pred(32'h0000_1000, 14'h2cb9);
    idle(1);

    // Prediction coinciding with the stage-2 write sees the old counter.
    upd(14'h0001, 1);
    pred(32'h0000_0004, 14'h0000);
    pred(32'h0000_0004, 14'h0000);
    idle(1);

    upd(14'h28b9, 1); upd(14'h28b9, 1);
    idle(2); pred(32'h0000_1000, 14'h2cb9); idle(1);
    upd(14'h28b9, 1); upd(14'h28b9, 1); upd(14'h28b9, 1); upd(14'h28b9, 0);
    idle(2); pred(32'h0000_1000, 14'h2cb9); idle(1);
    upd(14'h28b9, 0); upd(14'h28b9, 0);
    idle(2); pred(32'h0000_1000, 14'h2cb9); idle(1);

    for (int i = 0; i < 4; i++) upd(14'h0000, 0);
    idle(2); pred(32'h0, 14'h0); idle(1);

    for (int i = 0; i < 3000; i++) begin
      pc = $urandom;
      step($urandom_range(0, 9) < 7, pc,
           14'((pc >> 2) & 32'h3fff) ^ 14'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 6, 14'($urandom_range(0, 15)), 1'($urandom));
    end
    idle(2);

    upd(14'h28b9, 1); upd(14'h28b9, 1); upd(14'h28b9, 1);
    idle(2); pred(32'h0000_1000, 14'h2cb9); idle(1);
    upd(14'h28b9, 1);
    do_reset(1);

    for (int i = 0; i < 5000; i++)
      step(1'($urandom), $urandom, 14'($urandom), 1'($urandom), 14'($urandom), 1'($urandom));
    #1;
    chk("ready_mid_init", ready, 0);
    do_reset(1);
    run_init(rise);
    chk("reinit_cycles", rise, N);

    pred(32'h0000_1000, 14'h2cb9);
    pred(32'h0, 14'h0);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Pattern history table that consumes the 14-bit global history produced by sh_reg (its rd_data) and sits directly downstream of it in the predictor.
- Forms a gshare index from the branch PC XOR the history and returns a registered taken/not-taken prediction from 2-bit saturating counters.
- Accepts resolved-branch updates that train the counters.
- Self-initialises every counter after reset using a sweep state machine.

Parameters:
- PC_W, 32, branch PC width.
- HIST_W, 14, global history width; must match sh_reg.
- IDX_W, 14, table index width. Entries = 2**IDX_W. Requires IDX_W <= HIST_W and IDX_W+2 <= PC_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- pred_req  input  1  prediction request this cycle.
- pred_pc  input  PC_W  branch PC for the request.
- ghr  input  HIST_W  global history from the sh_reg rd_data output.
- pred_valid  output  1  prediction result valid; one-cycle pulse per accepted request.
- pred_taken  output  1  predicted direction (counter MSB).
- pred_idx  output  IDX_W  index used; software/pipeline carries it back for the update.
- upd_en  input  1  update request.
- upd_idx  input  IDX_W  index to train (the pred_idx returned earlier).
- upd_taken  input  1  resolved direction.
- ready  output  1  table initialised; requests are accepted only while ready=1.

Behaviour:
- Index: idx = pred_pc[IDX_W+1:2] XOR ghr[IDX_W-1:0].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = MSB.
- Reset (reset=0, asynchronous):
  - state=INIT, sweep counter=0.
  - ready=0, pred_valid=0, pred_taken=0, pred_idx=0, update stage valid=0.
  - The array itself is not reset; the sweep initialises it.
- FSM states: INIT, RUN.
  - INIT: each cycle writes array[sweep]=01 and increments sweep. When sweep==2**IDX_W-1 is written, the next state is RUN, and ready=1 from that edge.
  - INIT duration: exactly 2**IDX_W cycles after reset deassertion.
  - pred_req and upd_en are ignored in INIT: no pred_valid, no write.
  - RUN: terminal until reset.
- Reset mid-INIT or mid-RUN aborts everything and restarts the sweep from 0. Any captured update is discarded.
- Prediction, 1-cycle latency:
  - If pred_req=1 and state=RUN at edge T, then at T+1 pred_valid=1, pred_idx=idx, pred_taken=array[idx][1] as read before edge T's writes commit.
  - Otherwise pred_valid=0 and pred_taken/pred_idx hold their previous values.
- Update, 2 stages:
  - Stage 1: upd_en=1 in RUN registers upd_idx/upd_taken at edge E1.
  - Stage 2: reads array[idx_q] combinationally, computes the saturating increment (taken) or decrement (not taken), and writes at edge E2.
  - 11+taken stays 11; 00+not-taken stays 00.
  - Back-to-back updates to the same index need no forwarding, since each stage-2 read follows the prior write. Each of N consecutive updates takes effect.
- Simultaneous prediction and update to the same index: the prediction returns the value before the update that commits at that edge. There is no bypass.
- A prediction request and an update may be accepted every cycle; there is no backpressure in RUN.

Decomposition:
- Package gshare_pkg holds:
  - counter encoding constants (SNT/WNT/WT/ST), INIT_CTR=2'b01;
  - FSM state encodings INIT/RUN;
  - default widths.
- One sub-module: sat_ctr2, combinational 2-bit saturating next-value (cur, taken -> next), shared by the update stage.

Test Plan:
Use IDX_W=14, PC_W=32 unless noted.
1. Reset, then release: ready=0 for exactly 16384 cycles, then ready=1. pred_req asserted during INIT never produces pred_valid.
2. pred_pc=0x00001000, ghr=0x2cb9 after init: next cycle pred_valid=1, pred_idx=0x28b9, pred_taken=0.
3. Training:
   - upd_idx=0x28b9 with taken on 2 consecutive cycles, then predict (case 2 stimulus) -> pred_taken=1 (counter 11).
   - 3 more taken updates, then 1 not-taken -> counter 10, pred_taken=1.
   - 2 more not-taken updates -> counter 00, pred_taken=0.
4. Same cycle: pred_req for idx 0x28b9 and the stage-2 write of a taken update (counter 01->10) -> that prediction returns 0; a request issued on the following cycle returns 1.
5. Assert reset=0 for one cycle at cycle 5000 of INIT: ready stays 0, and ready rises 16384 cycles after release. A pending update is discarded.
6. Saturate low: 4 not-taken updates to idx 0x0000 -> counter stays 00, predict=0, with no wrap to 11.
